// File: rtl/snake_dir_queue.sv
// Per-player direction capture for the snake game: synchronise, debounce, and
// edge-detect the buttons, reject reversals, and queue moves for the game tick.
module snake_dir_queue #(
  parameter int NUM_PLAYERS = 2,
  parameter int DB_CYCLES   = 500000,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [4*NUM_PLAYERS-1:0] btn,
  input  logic                     clear,
  input  logic [NUM_PLAYERS-1:0]   pop,
  output logic [3*NUM_PLAYERS-1:0] head_dir,
  output logic [3*NUM_PLAYERS-1:0] cur_dir,
  output logic [NUM_PLAYERS-1:0]   q_empty,
  output logic [NUM_PLAYERS-1:0]   q_full,
  output logic [NUM_PLAYERS-1:0]   overflow
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);
  localparam logic [PW:0]   DEPTH  = (PW+1)'(QUEUE_DEPTH);

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;
  localparam logic [2:0] DIR_IDLE  = 3'd5;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0]    sync_a, sync_b, sync_prev, db, db_prev;
    logic [CW-1:0] cnt, cnt_eff;
    logic [2:0]    cand, last_dir, opp_last, cur;
    logic          cand_valid, accept, push, do_pop, empty, full, ovf;
    logic [2:0]    mem [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        sync_a <= '0;
        sync_b <= '0;
      end else begin
        sync_a <= btn[4*p +: 4];
        sync_b <= sync_a;
      end
    end

    // A new synchronised pattern starts its stability count from scratch.
    assign cnt_eff = (sync_b != sync_prev) ? '0 : cnt;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        sync_prev <= '0;
        db        <= '0;
        db_prev   <= '0;
        cnt       <= '0;
      end else begin
        sync_prev <= sync_b;
        db_prev   <= db;
        if (sync_b == db) begin
          cnt <= '0;
        end else if (cnt_eff == DB_MAX) begin
          db  <= sync_b;
          cnt <= '0;
        end else begin
          cnt <= cnt_eff + CW'(1);
        end
      end
    end

    always_comb begin
      cand       = DIR_NONE;
      cand_valid = 1'b0;
      if (db != db_prev) begin
        case (db)
          4'b1000: begin cand = DIR_UP;    cand_valid = 1'b1; end
          4'b0100: begin cand = DIR_RIGHT; cand_valid = 1'b1; end
          4'b0010: begin cand = DIR_DOWN;  cand_valid = 1'b1; end
          4'b0001: begin cand = DIR_LEFT;  cand_valid = 1'b1; end
          default: ;
        endcase
      end
    end

    always_comb begin
      case (last_dir)
        DIR_UP:    opp_last = DIR_DOWN;
        DIR_DOWN:  opp_last = DIR_UP;
        DIR_RIGHT: opp_last = DIR_LEFT;
        DIR_LEFT:  opp_last = DIR_RIGHT;
        default:   opp_last = DIR_NONE;
      endcase
    end

    assign empty  = (count == '0);
    assign full   = (count == DEPTH);
    assign accept = cand_valid && (cand != last_dir) && (cand != opp_last);
    assign do_pop = pop[p] && !empty;
    // A pop on the same edge frees a slot, so a full queue can still accept.
    assign push   = accept && (!full || do_pop);

    always_ff @(posedge clock) begin
      if (push && !clear) mem[wr_ptr] <= cand;
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        last_dir <= DIR_IDLE;
        cur      <= DIR_IDLE;
        ovf      <= 1'b0;
      end else if (clear) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        last_dir <= DIR_IDLE;
        cur      <= DIR_IDLE;
        ovf      <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PW'(1);
          last_dir <= cand;
        end else if (accept) begin
          ovf <= 1'b1;
        end
        if (do_pop) begin
          cur    <= mem[rd_ptr];
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, do_pop})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: ;
        endcase
      end
    end

    assign head_dir[3*p +: 3] = empty ? cur : mem[rd_ptr];
    assign cur_dir[3*p +: 3]  = cur;
    assign q_empty[p]         = empty;
    assign q_full[p]          = full;
    assign overflow[p]        = ovf;
  end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Bench for snake_dir_queue: a list-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_snake_dir_queue;

  localparam int NP = 2;
  localparam int DB = 8;
  localparam int QD = 4;

  logic          clock;
  logic          resetn;
  logic [7:0]    btn;
  logic          clear;
  logic [1:0]    pop;
  logic [5:0]    head_dir, cur_dir;
  logic [1:0]    q_empty, q_full, overflow;

  int  n_vec;
  int  n_err;
  bit  check_en;

  snake_dir_queue #(.NUM_PLAYERS(NP), .DB_CYCLES(DB), .QUEUE_DEPTH(QD)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .btn      (btn),
    .clear    (clear),
    .pop      (pop),
    .head_dir (head_dir),
    .cur_dir  (cur_dir),
    .q_empty  (q_empty),
    .q_full   (q_full),
    .overflow (overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model state: queue kept as a shifting list, debounce as a run-length count.
  int         m_q [NP][QD];
  int         m_n [NP];
  int         m_cur [NP];
  int         m_last [NP];
  bit         m_ovf [NP];
  logic [3:0] m_s1 [NP], m_s2 [NP], m_db [NP], m_dbp [NP], m_seen [NP];
  int         m_stable [NP];
  int         m_cand;

  function automatic int opposite(input int d);
    case (d)
      1: return 3;
      3: return 1;
      2: return 4;
      4: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int code_of(input logic [3:0] v);
    case (v)
      4'b1000: return 1;
      4'b0100: return 2;
      4'b0010: return 3;
      4'b0001: return 4;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < NP; p++) begin
        m_n[p] = 0; m_cur[p] = 5; m_last[p] = 5; m_ovf[p] = 0;
        m_s1[p] = '0; m_s2[p] = '0; m_db[p] = '0; m_dbp[p] = '0; m_seen[p] = '0;
        m_stable[p] = 0;
        for (int i = 0; i < QD; i++) m_q[p][i] = 0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        m_cand = (m_db[p] != m_dbp[p]) ? code_of(m_db[p]) : 0;
        if (clear) begin
          m_n[p] = 0; m_cur[p] = 5; m_last[p] = 5; m_ovf[p] = 0;
        end else begin
          if (pop[p] && m_n[p] > 0) begin
            m_cur[p] = m_q[p][0];
            for (int i = 0; i < QD-1; i++) m_q[p][i] = m_q[p][i+1];
            m_n[p]--;
          end
          if (m_cand != 0 && m_cand != m_last[p] && m_cand != opposite(m_last[p])) begin
            if (m_n[p] < QD) begin
              m_q[p][m_n[p]] = m_cand;
              m_n[p]++;
              m_last[p] = m_cand;
            end else begin
              m_ovf[p] = 1;
            end
          end
        end
        m_dbp[p] = m_db[p];
        if (m_s2[p] == m_db[p]) begin
          m_stable[p] = 0;
        end else begin
          m_stable[p] = (m_s2[p] != m_seen[p]) ? 1 : m_stable[p] + 1;
          if (m_stable[p] == DB) begin
            m_db[p]     = m_s2[p];
            m_stable[p] = 0;
          end
        end
        m_seen[p] = m_s2[p];
        m_s2[p]   = m_s1[p];
        m_s1[p]   = btn[4*p +: 4];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      logic [5:0] e_head, e_cur;
      logic [1:0] e_empty, e_full, e_ovf;
      for (int p = 0; p < NP; p++) begin
        e_head[3*p +: 3] = 3'((m_n[p] > 0) ? m_q[p][0] : m_cur[p]);
        e_cur[3*p +: 3]  = 3'(m_cur[p]);
        e_empty[p]       = (m_n[p] == 0);
        e_full[p]        = (m_n[p] == QD);
        e_ovf[p]         = m_ovf[p];
      end
      checkOutput("model_head_dir", {2'b0, head_dir}, {2'b0, e_head});
      checkOutput("model_cur_dir",  {2'b0, cur_dir},  {2'b0, e_cur});
      checkOutput("model_q_empty",  {6'b0, q_empty},  {6'b0, e_empty});
      checkOutput("model_q_full",   {6'b0, q_full},   {6'b0, e_full});
      checkOutput("model_overflow", {6'b0, overflow}, {6'b0, e_ovf});
    end
  end

  // Called just after a falling edge; returns just after a falling edge.
  task automatic applyStimulus(input logic [7:0] b, input logic [1:0] pp, input logic c,
                               input int cycles);
    btn = b; pop = pp; clear = c;
    @(negedge clock); #1;
    pop = '0; clear = 1'b0;
    repeat (cycles - 1) begin
      @(negedge clock); #1;
    end
  endtask

  task automatic press(input logic [7:0] b);
    applyStimulus(b, 2'b00, 1'b0, 14);
    applyStimulus(8'h00, 2'b00, 1'b0, 14);
  endtask

  initial begin
    n_vec = 0; n_err = 0; check_en = 0;
    btn = '0; pop = '0; clear = 1'b0; resetn = 1'b0;
    repeat (3) @(negedge clock);
    #1 resetn = 1'b1;
    check_en = 1;

    $display("[TB] reset / idle");
    applyStimulus(8'h00, 2'b00, 1'b0, 4);
    checkOutput("rst_head", {2'b0, head_dir}, 8'o55);
    checkOutput("rst_cur",  {2'b0, cur_dir},  8'o55);
    checkOutput("rst_empty", {6'b0, q_empty}, 8'h03);
    checkOutput("rst_ovf",   {6'b0, overflow}, 8'h00);

    $display("[TB] debounce");
    applyStimulus(8'h08, 2'b00, 1'b0, 5);
    applyStimulus(8'h00, 2'b00, 1'b0, 14);
    checkOutput("glitch_empty", {6'b0, q_empty}, 8'h03);
    applyStimulus(8'h08, 2'b00, 1'b0, 10);
    checkOutput("edge10_empty", {6'b0, q_empty}, 8'h03);
    applyStimulus(8'h08, 2'b00, 1'b0, 1);
    checkOutput("edge11_head", {5'b0, head_dir[2:0]}, 8'd1);
    checkOutput("edge11_empty", {6'b0, q_empty}, 8'h02);
    applyStimulus(8'h08, 2'b00, 1'b0, 9);
    applyStimulus(8'h00, 2'b00, 1'b0, 14);
    checkOutput("held_once_empty", {6'b0, q_empty}, 8'h02);
    applyStimulus(8'h00, 2'b01, 1'b0, 1);
    checkOutput("pop_cur", {5'b0, cur_dir[2:0]}, 8'd1);
    checkOutput("pop_empty", {6'b0, q_empty}, 8'h03);

    $display("[TB] reversal filter");
    applyStimulus(8'h00, 2'b00, 1'b1, 2);
    press(8'h08); press(8'h08); press(8'h02); press(8'h04);
    checkOutput("rev_head", {5'b0, head_dir[2:0]}, 8'd1);
    applyStimulus(8'h00, 2'b01, 1'b0, 1);
    checkOutput("rev_pop1_cur",  {5'b0, cur_dir[2:0]}, 8'd1);
    checkOutput("rev_pop1_head", {5'b0, head_dir[2:0]}, 8'd2);
    applyStimulus(8'h00, 2'b01, 1'b0, 1);
    checkOutput("rev_pop2_cur", {5'b0, cur_dir[2:0]}, 8'd2);
    checkOutput("rev_pop2_empty", {6'b0, q_empty}, 8'h03);

    $display("[TB] overflow");
    applyStimulus(8'h00, 2'b00, 1'b1, 2);
    press(8'h04); press(8'h02); press(8'h01); press(8'h08); press(8'h04);
    checkOutput("ovf_full", {6'b0, q_full}, 8'h01);
    checkOutput("ovf_flag", {6'b0, overflow}, 8'h01);
    checkOutput("ovf_head", {5'b0, head_dir[2:0]}, 8'd2);
    applyStimulus(8'h00, 2'b01, 1'b0, 1);
    checkOutput("ovf_pop1", {5'b0, cur_dir[2:0]}, 8'd2);
    applyStimulus(8'h00, 2'b01, 1'b0, 1);
    checkOutput("ovf_pop2", {5'b0, cur_dir[2:0]}, 8'd3);
    applyStimulus(8'h00, 2'b01, 1'b0, 1);
    checkOutput("ovf_pop3", {5'b0, cur_dir[2:0]}, 8'd4);
    applyStimulus(8'h00, 2'b01, 1'b0, 1);
    checkOutput("ovf_pop4", {5'b0, cur_dir[2:0]}, 8'd1);

    $display("[TB] full queue with simultaneous pop");
    applyStimulus(8'h00, 2'b00, 1'b1, 2);
    checkOutput("clr_ovf", {6'b0, overflow}, 8'h00);
    press(8'h04); press(8'h02); press(8'h01); press(8'h08);
    applyStimulus(8'h04, 2'b00, 1'b0, 10);
    applyStimulus(8'h04, 2'b01, 1'b0, 1);
    applyStimulus(8'h04, 2'b00, 1'b0, 3);
    applyStimulus(8'h00, 2'b00, 1'b0, 14);
    checkOutput("popov_full", {6'b0, q_full}, 8'h01);
    checkOutput("popov_flag", {6'b0, overflow}, 8'h00);
    checkOutput("popov_cur",  {5'b0, cur_dir[2:0]}, 8'd2);
    checkOutput("popov_head", {5'b0, head_dir[2:0]}, 8'd3);

    $display("[TB] independence");
    applyStimulus(8'h00, 2'b00, 1'b1, 2);
    press(8'h1C);
    checkOutput("ind_p1_head", {5'b0, head_dir[5:3]}, 8'd4);
    checkOutput("ind_empty", {6'b0, q_empty}, 8'h01);
    applyStimulus(8'h00, 2'b01, 1'b0, 1);
    checkOutput("ind_p0_cur", {5'b0, cur_dir[2:0]}, 8'd5);

    $display("[TB] clear mid-operation");
    applyStimulus(8'h00, 2'b00, 1'b1, 2);
    press(8'h08); press(8'h04); press(8'h02);
    applyStimulus(8'h01, 2'b00, 1'b0, 10);
    applyStimulus(8'h01, 2'b01, 1'b1, 1);
    checkOutput("clr_empty", {6'b0, q_empty}, 8'h03);
    checkOutput("clr_cur", {2'b0, cur_dir}, 8'o55);
    checkOutput("clr_flag", {6'b0, overflow}, 8'h00);
    applyStimulus(8'h01, 2'b00, 1'b0, 6);
    applyStimulus(8'h00, 2'b00, 1'b0, 14);
    checkOutput("clr_held_empty", {6'b0, q_empty}, 8'h03);

    $display("[TB] async reset mid-debounce");
    press(8'h80);
    checkOutput("pre_rst_empty", {6'b0, q_empty}, 8'h01);
    applyStimulus(8'h08, 2'b00, 1'b0, 5);
    #2 resetn = 1'b0;
    #1;
    checkOutput("arst_head",  {2'b0, head_dir}, 8'o55);
    checkOutput("arst_cur",   {2'b0, cur_dir},  8'o55);
    checkOutput("arst_empty", {6'b0, q_empty},  8'h03);
    checkOutput("arst_full",  {6'b0, q_full},   8'h00);
    checkOutput("arst_ovf",   {6'b0, overflow}, 8'h00);
    btn = '0;
    repeat (3) @(negedge clock);
    #1 resetn = 1'b1;
    applyStimulus(8'h00, 2'b00, 1'b0, 20);
    checkOutput("post_rst_empty", {6'b0, q_empty}, 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snake_dir_queue.md
# snake_dir_queue

Parametrised per-player direction input block for the snake game: replaces the combinational button-to-move decode in the top level with synchronised, debounced, edge-triggered direction capture and a per-player move queue. Sits between the board buttons and the processor/VGA game logic; game logic pops one queued move per game tick, so fast key sequences (e.g. up-then-left within one tick) are not lost and illegal 180° reversals are filtered in hardware.

## Interface
- NUM_PLAYERS, 2, number of independent players/channels (1..4)
- DB_CYCLES, 500000, cycles a synchronised button pattern must be stable before it is accepted (≥1)
- QUEUE_DEPTH, 4, move queue entries per player (power of 2, ≥2)

- clock  in  1  system clock; all logic rising-edge
- resetn  in  1  asynchronous, active-low reset
- btn  in  4*NUM_PLAYERS  raw buttons, player p at [4p+3:4p] = {up,right,down,left}, active-high, asynchronous to clock
- clear  in  1  synchronous game restart: flush queues and direction state
- pop  in  NUM_PLAYERS  consume head move for player p (one per tick)
- head_dir  out  3*NUM_PLAYERS  player p at [3p+2:3p]: queue head if non-empty, else cur_dir
- cur_dir  out  3*NUM_PLAYERS  last popped (committed) direction
- q_empty  out  NUM_PLAYERS  queue p empty
- q_full  out  NUM_PLAYERS  queue p holds QUEUE_DEPTH entries
- overflow  out  NUM_PLAYERS  sticky: a legal move was dropped because queue p was full

## Operation
- Direction code: 1=up, 2=right, 3=down, 4=left, 5=idle (no move yet). Opposites: 1↔3, 2↔4.
- Per player: 2-flop synchroniser on each btn bit → debouncer → edge detect → filter → FIFO.
- Debouncer: register db (4 bits, reset 0). Counter resets whenever sync value equals db; otherwise increments; when counter reaches DB_CYCLES-1 with sync still ≠ db, db ← sync and counter clears. Any change in sync during counting restarts the count.
- Candidate: on the cycle db changes to a one-hot pattern, produce that code. Zero or multi-hot patterns produce nothing. Holding a button produces exactly one candidate.
- Filter against last_dir (most recently accepted code, reset 5): reject if candidate == last_dir or candidate == opposite(last_dir). Accepted → enqueue, last_dir ← candidate. last_dir is independent of pops.
- Full queue: accepted candidate dropped, overflow[p] ← 1, last_dir unchanged. If pop[p] is asserted the same cycle, the slot frees and the push succeeds (no overflow).
- Pop: if non-empty, cur_dir ← head, head advances. Pop on empty ignored, cur_dir holds.
- Push into empty queue with simultaneous pop: pop ignored (evaluated against pre-edge state), push lands.
- clear (priority over push/pop): queues empty, last_dir=5, cur_dir=5, overflow=0; debouncers and synchronisers untouched, so a button held across clear does not re-enqueue.
- Players fully independent; no cross-player interaction.

## Timing
- Reset values: head_dir=5, cur_dir=5 (all players), q_empty=all 1, q_full=0, overflow=0, db=0, counters=0, pointers=0.
- Latency: raw btn stable from edge 0 → sync valid after edge 2 → db updates at edge 2+DB_CYCLES → entry visible (q_empty low, head_dir valid) after edge 3+DB_CYCLES.
- Pop: cur_dir/head_dir/q_empty/q_full update after the sampling edge; all outputs registered or decoded from registers only, no combinational path from btn or pop to outputs.
- Pointers wrap modulo QUEUE_DEPTH; occupancy counter width log2(QUEUE_DEPTH)+1.
- resetn asserted mid-operation: all state returns to reset values immediately, regardless of clock.

## Test plan
- Reset/idle: release resetn, no buttons → head_dir=cur_dir=5 for both players, q_empty=2'b11, overflow=0.
- Debounce (DB_CYCLES=8): player0 up pulsed 5 cycles → no enqueue; held 20 cycles → exactly one entry, head_dir[2:0]=1 after edge 11 from first sampling; pop → cur_dir=1, q_empty[0]=1.
- Reversal filter: press up, release, press down, release, press right → queue holds {1,2}; down rejected; repeated up also rejected.
- Overflow (QUEUE_DEPTH=4): enqueue right,down,left,up,right without popping → 4 entries {2,3,4,1}, fifth dropped, overflow[0]=1, q_full[0]=1; repeat with pop asserted on the fifth accept → no overflow, queue {3,4,1,2}.
- Independence/simultaneity: player1 left while player0 up+right together → player1 gets 4, player0 nothing (multi-hot); pop on empty player0 → cur_dir stays 5.
- Clear/reset mid-operation: queue 3 entries, assert clear with pop and button edge same cycle → all queues empty, cur_dir=5, overflow=0; later assert resetn low mid-debounce → outputs at reset values asynchronously.
